cache_arbiter: RTL

- Shares one physical-memory port between the instruction cache (read-only) and the data cache (read/write) in the pipelined LC-3b.
- Sits between both L1 cache controllers and pmem.
- Grants one requester at a time and holds the grant until pmem_resp.
- Moves whole 128-bit lc3b_block lines.

---
 rtl/lc3b_types.sv | 15 +
 rtl/arb_grant_sel.sv | 23 ++
 rtl/cache_arbiter.sv | 114 +++++++++++
 3 files changed

// File: rtl/lc3b_types.sv
// Shared LC-3b types: machine word, cache line, line-offset width and arbiter FSM states.
package lc3b_types;

  typedef logic [15:0]  lc3b_word;
  typedef logic [127:0] lc3b_block;

  localparam int LC3B_LINE_OFF_BITS = 4;

  typedef enum logic [1:0] {
    ARB_IDLE,
    ARB_SERVE_I,
    ARB_SERVE_D
  } arb_state;

endpackage

// File: rtl/arb_grant_sel.sv
// Combinational winner select between icache and dcache requests.
// CACHE_ARB_RR_EN selects round-robin on ties; otherwise the dcache always wins ties.
module arb_grant_sel (
  input  logic i_req,
  input  logic d_req,
  input  logic last_d,
  output logic grant_i,
  output logic grant_d
);

`ifdef CACHE_ARB_RR_EN
  // On a tie, the side not served last time goes next.
  assign grant_d = d_req & (~i_req | ~last_d);
  assign grant_i = i_req & (~d_req | last_d);
`else
  // The MEM-stage (dcache) request is older than IF, so it wins every tie.
  logic unused_last_d;
  assign unused_last_d = last_d;
  assign grant_d       = d_req;
  assign grant_i       = i_req & ~d_req;
`endif

endmodule

// File: rtl/cache_arbiter.sv
// Shares one pmem port between icache and dcache, one whole-line transaction at a time.
// Tie-break policy is set in arb_grant_sel by the CACHE_ARB_RR_EN macro.
module cache_arbiter
  import lc3b_types::*;
#(
  parameter int ADDR_W = $bits(lc3b_word),
  parameter int LINE_W = $bits(lc3b_block),
  parameter int OFF_W  = LC3B_LINE_OFF_BITS
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              i_read,
  input  logic [ADDR_W-1:0] i_address,
  output logic [LINE_W-1:0] i_rdata,
  output logic              i_resp,
  input  logic              d_read,
  input  logic              d_write,
  input  logic [ADDR_W-1:0] d_address,
  input  logic [LINE_W-1:0] d_wdata,
  output logic [LINE_W-1:0] d_rdata,
  output logic              d_resp,
  output logic              pmem_read,
  output logic              pmem_write,
  output logic [ADDR_W-1:0] pmem_address,
  output logic [LINE_W-1:0] pmem_wdata,
  input  logic [LINE_W-1:0] pmem_rdata,
  input  logic              pmem_resp
);

  arb_state          state, state_nxt;
  logic              last_d;
  logic              d_wr_q;
  logic [ADDR_W-1:0] addr_q;
  logic [LINE_W-1:0] wdata_q;
  logic              grant_i, grant_d;

  // Offset bits are cleared on the way to pmem, so they never reach any logic.
  logic unused_offsets;
  assign unused_offsets = ^{i_address[OFF_W-1:0], d_address[OFF_W-1:0]};

  arb_grant_sel u_grant_sel (
    .i_req   (i_read),
    .d_req   (d_read | d_write),
    .last_d  (last_d),
    .grant_i (grant_i),
    .grant_d (grant_d)
  );

  // NOTE: every output gets a default before the case so no path infers a latch.
  always_comb begin
    state_nxt    = state;
    pmem_read    = 1'b0;
    pmem_write   = 1'b0;
    pmem_address = '0;
    pmem_wdata   = '0;
    i_resp       = 1'b0;
    i_rdata      = '0;
    d_resp       = 1'b0;
    d_rdata      = '0;
    case (state)
      ARB_IDLE: begin
        if (grant_d)      state_nxt = ARB_SERVE_D;
        else if (grant_i) state_nxt = ARB_SERVE_I;
      end
      ARB_SERVE_I: begin
        pmem_read    = 1'b1;
        pmem_address = addr_q;
        if (pmem_resp) begin
          i_resp    = 1'b1;
          i_rdata   = pmem_rdata;
          state_nxt = ARB_IDLE;
        end
      end
      ARB_SERVE_D: begin
        pmem_write   = d_wr_q;
        pmem_read    = ~d_wr_q;
        pmem_address = addr_q;
        pmem_wdata   = wdata_q;
        if (pmem_resp) begin
          d_resp    = 1'b1;
          d_rdata   = pmem_rdata;
          state_nxt = ARB_IDLE;
        end
      end
      default: state_nxt = ARB_IDLE;
    endcase
  end

  // NOTE: non-blocking assignments keep every register reading pre-edge values.
  // NOTE: the latched line data is reset too; it is a single register, not a memory array.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= ARB_IDLE;
      last_d  <= 1'b0;
      d_wr_q  <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
    end else begin
      state <= state_nxt;
      if (state == ARB_IDLE) begin
        if (grant_d) begin
          addr_q  <= {d_address[ADDR_W-1:OFF_W], {OFF_W{1'b0}}};
          wdata_q <= d_wdata;
          d_wr_q  <= d_write;
        end else if (grant_i) begin
          addr_q  <= {i_address[ADDR_W-1:OFF_W], {OFF_W{1'b0}}};
        end
      end
      if (pmem_resp && state != ARB_IDLE)
        last_d <= (state == ARB_SERVE_D);
    end
  end

endmodule
